// File: rtl/gf_pkg.sv
// gf_pkg: shared Reed-Solomon decoder constants and types.
//   Code geometry (symbol width, T_LEN, N_LEN, roots per Chien beat, beats
//   per codeword) plus the widths and types that the error-position collector
//   and its compactor use.
package gf_pkg;

  localparam int SYMB_WIDTH        = 8;
  localparam int T_LEN             = 8;
  localparam int N_LEN             = 255;
  localparam int ROOTS_PER_CYCLE   = 8;
  localparam int CYCLES_NUM__CHIEN = (N_LEN + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;

  localparam int POS_WIDTH  = $clog2(N_LEN);
  localparam int CNT_WIDTH  = $clog2(T_LEN + 1);
  localparam int BEAT_WIDTH = $clog2(CYCLES_NUM__CHIEN);
  localparam int POP_WIDTH  = $clog2(ROOTS_PER_CYCLE + 1);
  // Wide enough to hold write index + popcount without wrapping.
  localparam int SUM_WIDTH  = ((CNT_WIDTH > POP_WIDTH) ? CNT_WIDTH : POP_WIDTH) + 1;

  typedef logic [POS_WIDTH-1:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } collect_state_t;

endpackage

// File: rtl/rs_hit_compact.sv
// rs_hit_compact: combinational prefix-popcount packer.
//   Every set bit i of the masked hit vector is written to list slot
//   wr_idx + (number of set bits below i), carrying position base + i.
//   Slots at or beyond T_LEN are simply never enabled.
// Ports:
//   hit       - masked root-hit vector of the current beat
//   base      - symbol position of bit 0 of this beat
//   wr_idx    - first free list slot
//   slot_we   - per-slot write enable
//   slot_data - per-slot position to write
//   pop_cnt   - number of set bits in hit
module rs_hit_compact
  import gf_pkg::*;
(
  input  logic [ROOTS_PER_CYCLE-1:0] hit,
  input  pos_t                       base,
  input  logic [CNT_WIDTH-1:0]       wr_idx,
  output logic [T_LEN-1:0]           slot_we,
  output pos_t [T_LEN-1:0]           slot_data,
  output logic [POP_WIDTH-1:0]       pop_cnt
);

  logic [SUM_WIDTH-1:0] prefix;
  logic [SUM_WIDTH-1:0] slot;

  always_comb begin
    slot_we   = '0;
    slot_data = '0;
    prefix    = '0;
    slot      = '0;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
      if (hit[i]) begin
        slot = SUM_WIDTH'(wr_idx) + prefix;
        for (int k = 0; k < T_LEN; k++) begin
          if (slot == SUM_WIDTH'(k)) begin
            slot_we[k]   = 1'b1;
            slot_data[k] = base + pos_t'(i);
          end
        end
        prefix = prefix + SUM_WIDTH'(1);
      end
    end
    pop_cnt = prefix[POP_WIDTH-1:0];
  end

endmodule

// File: rtl/rs_err_pos_collect.sv
// rs_err_pos_collect: turns Chien-search root hits into an ascending list of
// up to T_LEN error positions, checks the count against the error-locator
// degree and offers the result downstream.
// Handshake: a beat transfers on a cycle where in_vld && in_rdy; a result
//   transfers on a cycle where out_vld && out_rdy. out_* stay stable while
//   out_vld && !out_rdy, and in_rdy is low for as long as a result is held.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_vld/in_rdy/in_sop/in_hit/in_deg - beat stream from the Chien search
//   out_vld/out_rdy  - result handshake
//   out_pos    - error positions, ascending, packed from index 0
//   out_pos_en - valid flag per out_pos entry
//   out_num    - error count, saturating at T_LEN
//   out_fail   - codeword uncorrectable
//   dbg_state  - current FSM state
module rs_err_pos_collect
  import gf_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic                       in_sop,
  input  logic [ROOTS_PER_CYCLE-1:0] in_hit,
  input  logic [CNT_WIDTH-1:0]       in_deg,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output pos_t [T_LEN-1:0]           out_pos,
  output logic [T_LEN-1:0]           out_pos_en,
  output logic [CNT_WIDTH-1:0]       out_num,
  output logic                       out_fail,
  output collect_state_t             dbg_state
);

  localparam pos_t RPC = pos_t'(ROOTS_PER_CYCLE);

  collect_state_t        state;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0]  wr_idx;
  logic [CNT_WIDTH-1:0]  deg_q;
  logic                  ovf_q;
  logic                  fail_q;
  pos_t [T_LEN-1:0]      pos_q;
  logic [T_LEN-1:0]      pos_en_q;

  // Per-beat datapath
  logic                       accept;
  logic                       take;
  logic [BEAT_WIDTH-1:0]      beat_eff;
  logic [CNT_WIDTH-1:0]       idx_eff;
  logic [CNT_WIDTH-1:0]       deg_eff;
  pos_t                       base;
  logic [POS_WIDTH:0]         pos_full;
  logic [ROOTS_PER_CYCLE-1:0] hit_mask;
  logic [ROOTS_PER_CYCLE-1:0] hit_m;
  logic [T_LEN-1:0]           slot_we;
  pos_t [T_LEN-1:0]           slot_data;
  logic [POP_WIDTH-1:0]       pop_cnt;
  logic [SUM_WIDTH-1:0]       sum;
  logic                       ovf_now;
  logic                       ovf_next;
  logic [CNT_WIDTH-1:0]       idx_next;
  logic                       last_beat;
  logic                       fail_next;
  pos_t [T_LEN-1:0]           pos_next;
  logic [T_LEN-1:0]           pos_en_next;

  assign in_rdy = (state != ST_HOLD);
  assign accept = in_vld && in_rdy;
  // In IDLE only a sop beat starts work; in COLLECT every beat counts.
  assign take   = accept && (in_sop || (state == ST_COLLECT));

  // A sop beat (also mid-frame) restarts as beat 0 with an empty list.
  assign beat_eff = in_sop ? '0 : beat_cnt;
  assign idx_eff  = in_sop ? '0 : wr_idx;
  assign deg_eff  = in_sop ? in_deg : deg_q;
  assign base     = pos_t'(beat_eff) * RPC;

  // Drop hits beyond the codeword end (only possible in the last beat).
  always_comb begin
    hit_mask = '0;
    pos_full = '0;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
      pos_full    = {1'b0, base} + (POS_WIDTH + 1)'(i);
      hit_mask[i] = (pos_full < (POS_WIDTH + 1)'(N_LEN));
    end
  end

  assign hit_m = in_hit & hit_mask;

  rs_hit_compact u_compact (
    .hit       (hit_m),
    .base      (base),
    .wr_idx    (idx_eff),
    .slot_we   (slot_we),
    .slot_data (slot_data),
    .pop_cnt   (pop_cnt)
  );

  assign sum       = SUM_WIDTH'(idx_eff) + SUM_WIDTH'(pop_cnt);
  assign ovf_now   = (sum > SUM_WIDTH'(T_LEN));
  assign idx_next  = ovf_now ? CNT_WIDTH'(T_LEN) : sum[CNT_WIDTH-1:0];
  assign ovf_next  = (in_sop ? 1'b0 : ovf_q) | ovf_now;
  assign last_beat = (beat_eff == BEAT_WIDTH'(CYCLES_NUM__CHIEN - 1));
  assign fail_next = ovf_next || (idx_next != deg_eff) ||
                     ((deg_eff == '0) && (idx_next != '0));

  always_comb begin
    pos_next    = pos_q;
    pos_en_next = pos_en_q;
    if (in_sop) begin
      pos_next    = '0;
      pos_en_next = '0;
    end
    for (int k = 0; k < T_LEN; k++) begin
      if (slot_we[k]) begin
        pos_next[k]    = slot_data[k];
        pos_en_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      wr_idx   <= '0;
      deg_q    <= '0;
      ovf_q    <= 1'b0;
      fail_q   <= 1'b0;
      pos_q    <= '0;
      pos_en_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (take) begin
            pos_q    <= pos_next;
            pos_en_q <= pos_en_next;
            wr_idx   <= idx_next;
            ovf_q    <= ovf_next;
            deg_q    <= deg_eff;
            if (in_sop) begin
              fail_q <= 1'b0;
            end
            if (last_beat) begin
              state    <= ST_HOLD;
              beat_cnt <= '0;
              fail_q   <= fail_next;
            end else begin
              state    <= ST_COLLECT;
              beat_cnt <= beat_eff + BEAT_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_vld    = (state == ST_HOLD);
  assign out_pos    = pos_q;
  assign out_pos_en = pos_en_q;
  assign out_num    = wr_idx;
  assign out_fail   = fail_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_rs_err_pos_collect.sv
// Testbench for rs_err_pos_collect: frames are built in hits_buf, the
// expected result is computed from hits_buf and pushed to exp_q before the
// frame is driven, then popped and compared when the result is offered.
module tb_rs_err_pos_collect;
  import gf_pkg::*;

  localparam int POS_BITS = T_LEN * POS_WIDTH;
  localparam int EXP_W    = POS_BITS + T_LEN + CNT_WIDTH + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                       in_vld;
  logic                       in_rdy;
  logic                       in_sop;
  logic [ROOTS_PER_CYCLE-1:0] in_hit;
  logic [CNT_WIDTH-1:0]       in_deg;
  logic                       out_vld;
  logic                       out_rdy;
  logic [T_LEN-1:0][POS_WIDTH-1:0] out_pos;
  logic [T_LEN-1:0]           out_pos_en;
  logic [CNT_WIDTH-1:0]       out_num;
  logic                       out_fail;
  collect_state_t             dbg_state;

  rs_err_pos_collect dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_sop     (in_sop),
    .in_hit     (in_hit),
    .in_deg     (in_deg),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_pos    (out_pos),
    .out_pos_en (out_pos_en),
    .out_num    (out_num),
    .out_fail   (out_fail),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  logic [EXP_W-1:0]           exp_q[$];
  int                         checks   = 0;
  int                         failures = 0;
  logic [ROOTS_PER_CYCLE-1:0] hits_buf [CYCLES_NUM__CHIEN];

  // Reference: walk every symbol position in order.
  function automatic logic [EXP_W-1:0] model(input int deg);
    logic [T_LEN-1:0][POS_WIDTH-1:0] p;
    logic [T_LEN-1:0] en;
    logic [CNT_WIDTH-1:0] num;
    logic fail;
    int cnt;
    int pos;
    p   = '0;
    en  = '0;
    cnt = 0;
    for (int b = 0; b < CYCLES_NUM__CHIEN; b++) begin
      for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
        pos = b * ROOTS_PER_CYCLE + i;
        if (hits_buf[b][i] && pos < N_LEN) begin
          if (cnt < T_LEN) begin
            p[cnt]  = POS_WIDTH'(pos);
            en[cnt] = 1'b1;
          end
          cnt++;
        end
      end
    end
    num  = (cnt > T_LEN) ? CNT_WIDTH'(T_LEN) : CNT_WIDTH'(cnt);
    fail = (cnt > T_LEN) || (cnt != deg) || (deg == 0 && cnt != 0);
    return {p, en, num, fail};
  endfunction

  // driver tasks
  task automatic idle_inputs();
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_hit = '0;
    in_deg = '0;
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic drive_beat(input logic vld, input logic sop,
                            input logic [ROOTS_PER_CYCLE-1:0] hit,
                            input int deg);
    in_vld = vld;
    in_sop = sop;
    in_hit = hit;
    in_deg = CNT_WIDTH'(deg);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_hits();
    for (int b = 0; b < CYCLES_NUM__CHIEN; b++) hits_buf[b] = '0;
  endtask

  task automatic set_hit(input int p);
    hits_buf[p / ROOTS_PER_CYCLE][p % ROOTS_PER_CYCLE] = 1'b1;
  endtask

  task automatic send_frame(input int deg);
    for (int b = 0; b < CYCLES_NUM__CHIEN; b++)
      drive_beat(1'b1, (b == 0), hits_buf[b], deg);
    idle_inputs();
  endtask

  // Called right after send_frame: out_vld must already be high.
  task automatic check_result(input string name, input int hold_cycles);
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] got;
    int n;
    checks++;
    if (out_vld !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: out_vld=%b required 1 one cycle after last beat", name, out_vld);
    end
    n = 0;
    while (out_vld !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: queue empty", name);
      return;
    end
    exp = exp_q.pop_front();
    if (out_vld !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: out_vld never rose", name);
      return;
    end
    got = {out_pos, out_pos_en, out_num, out_fail};
    checks++;
    if (got[EXP_W-1 -: POS_BITS] !== exp[EXP_W-1 -: POS_BITS]) begin
      failures++;
      $display("FAIL %s out_pos: got %h required %h", name,
               got[EXP_W-1 -: POS_BITS], exp[EXP_W-1 -: POS_BITS]);
    end
    checks++;
    if (got[T_LEN+CNT_WIDTH:CNT_WIDTH+1] !== exp[T_LEN+CNT_WIDTH:CNT_WIDTH+1]) begin
      failures++;
      $display("FAIL %s out_pos_en: got %b required %b", name,
               got[T_LEN+CNT_WIDTH:CNT_WIDTH+1], exp[T_LEN+CNT_WIDTH:CNT_WIDTH+1]);
    end
    checks++;
    if (got[CNT_WIDTH:1] !== exp[CNT_WIDTH:1]) begin
      failures++;
      $display("FAIL %s out_num: got %0d required %0d", name, got[CNT_WIDTH:1], exp[CNT_WIDTH:1]);
    end
    checks++;
    if (got[0] !== exp[0]) begin
      failures++;
      $display("FAIL %s out_fail: got %b required %b", name, got[0], exp[0]);
    end
    for (int c = 0; c < hold_cycles; c++) begin
      out_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_pos, out_pos_en, out_num, out_fail} !== exp ||
          out_vld !== 1'b1 || in_rdy !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d: vld=%b rdy=%b data=%h required vld=1 rdy=0 data=%h",
                 name, c, out_vld, in_rdy, {out_pos, out_pos_en, out_num, out_fail}, exp);
      end
    end
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    idle_inputs();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL %s release: vld=%b rdy=%b state=%0d required vld=0 rdy=1 state=IDLE",
               name, out_vld, in_rdy, dbg_state);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out_pos !== '0 || out_pos_en !== '0 ||
        out_num !== '0 || out_fail !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL %s: rdy=%b vld=%b pos=%h en=%b num=%0d fail=%b state=%0d required 1 0 0 0 0 0 IDLE",
               name, in_rdy, out_vld, out_pos, out_pos_en, out_num, out_fail, dbg_state);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle_inputs();
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    pulse_reset();
    check_reset_values("reset");
  endtask

  task automatic test_basic();
    clear_hits();
    set_hit(5); set_hit(17); set_hit(200);
    exp_q.push_back(model(3));
    send_frame(3);
    check_result("basic", 0);
  endtask

  task automatic test_same_beat();
    clear_hits();
    set_hit(8); set_hit(9); set_hit(15);
    exp_q.push_back(model(3));
    for (int b = 0; b < CYCLES_NUM__CHIEN; b++) begin
      drive_beat(1'b1, (b == 0), hits_buf[b], 3);
      if (b == 0) begin
        checks++;
        if (out_num !== 4'd0 || out_pos_en !== '0) begin
          failures++;
          $display("FAIL same_beat b0: num=%0d en=%b required 0 0", out_num, out_pos_en);
        end
      end
      if (b == 1) begin
        checks++;
        if (out_num !== 4'd3 || out_pos_en !== 8'b0000_0111 ||
            {out_pos[2], out_pos[1], out_pos[0]} !== {8'd15, 8'd9, 8'd8}) begin
          failures++;
          $display("FAIL same_beat b1: num=%0d en=%b pos=%h required 3 00000111 0f0908",
                   out_num, out_pos_en, {out_pos[2], out_pos[1], out_pos[0]});
        end
      end
    end
    idle_inputs();
    check_result("same_beat", 0);
  endtask

  task automatic test_overflow();
    clear_hits();
    set_hit(3); set_hit(30); set_hit(60); set_hit(90); set_hit(120);
    set_hit(150); set_hit(180); set_hit(210); set_hit(240);
    exp_q.push_back(model(2));
    send_frame(2);
    check_result("overflow", 0);
  endtask

  task automatic test_last_beat();
    clear_hits();
    hits_buf[CYCLES_NUM__CHIEN-1] = 8'h80;
    exp_q.push_back(model(0));
    send_frame(0);
    check_result("last_beat_oob", 0);
  endtask

  task automatic test_deg_mismatch();
    clear_hits();
    set_hit(254);
    exp_q.push_back(model(0));
    send_frame(0);
    check_result("deg0_with_hit", 0);
    clear_hits();
    set_hit(0); set_hit(100);
    exp_q.push_back(model(3));
    send_frame(3);
    check_result("deg_too_high", 0);
  endtask

  task automatic test_idle_drop();
    for (int b = 0; b < 3; b++) drive_beat(1'b1, 1'b0, 8'hff, 4);
    idle_inputs();
    checks++;
    if (dbg_state !== ST_IDLE || out_vld !== 1'b0) begin
      failures++;
      $display("FAIL idle_drop: state=%0d vld=%b required IDLE 0", dbg_state, out_vld);
    end
    clear_hits();
    set_hit(77);
    exp_q.push_back(model(1));
    send_frame(1);
    check_result("after_idle_drop", 0);
  endtask

  task automatic test_backpressure();
    clear_hits();
    set_hit(1); set_hit(2); set_hit(250);
    exp_q.push_back(model(3));
    send_frame(3);
    in_vld = 1'b1;
    in_sop = 1'b1;
    in_hit = '1;
    in_deg = 4'd1;
    check_result("backpressure", 5);
    clear_hits();
    set_hit(44);
    exp_q.push_back(model(1));
    send_frame(1);
    check_result("after_backpressure", 0);
  endtask

  task automatic test_abort();
    for (int b = 0; b < 10; b++) drive_beat(1'b1, (b == 0), 8'h81, 5);
    clear_hits();
    set_hit(7); set_hit(100);
    exp_q.push_back(model(2));
    send_frame(2);
    check_result("abort_restart", 0);
  endtask

  task automatic test_abort_reset();
    int vld_seen;
    vld_seen = 0;
    for (int b = 0; b < 10; b++) begin
      drive_beat(1'b1, (b == 0), ROOTS_PER_CYCLE'($urandom_range(0, 255)), 2);
      if (out_vld !== 1'b0) vld_seen++;
    end
    for (int b = 0; b <= 20; b++) begin
      drive_beat(1'b1, (b == 0), ROOTS_PER_CYCLE'($urandom_range(0, 255)), 3);
      if (out_vld !== 1'b0) vld_seen++;
    end
    pulse_reset();
    check_reset_values("abort_reset");
    repeat (4) begin
      @(negedge clk);
      if (out_vld !== 1'b0) vld_seen++;
    end
    checks++;
    if (vld_seen != 0) begin
      failures++;
      $display("FAIL abort_reset out_vld: seen %0d cycles high required 0", vld_seen);
    end
  endtask

  task automatic test_random();
    int n;
    int deg;
    for (int r = 0; r < 6; r++) begin
      clear_hits();
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++) set_hit($urandom_range(0, 255));
      deg = $urandom_range(0, T_LEN);
      exp_q.push_back(model(deg));
      send_frame(deg);
      check_result($sformatf("random%0d", r), $urandom_range(0, 2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_rdy = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_same_beat();
    test_overflow();
    test_last_beat();
    test_deg_mismatch();
    test_idle_drop();
    test_backpressure();
    test_abort();
    test_abort_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d results left required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
